flash_op_arbiter: RTL
=====================

# flash_op_arbiter

Round-robin arbiter that shares the single flash-controller operation port among `N_REQ` per-channel scheduler instances. It grants one requester at a time and latches that requester's operation fields onto the shared port. It then tracks the controller's ready/busy line through acknowledge and completion, and returns a one-cycle `done` or `error` pulse to the granted requester. It sits between the schedulers and the clock-domain synchronizer that feeds the flash controller.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `PAGE_W`, 17: width of the page offset field.
- `ACK_TIMEOUT`, 64: maximum cycles to wait for the controller to go busy after issue.

Ports:
- `clk`  in  1  200 MHz system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  `N_REQ`  per-requester request; held high until `req_done` or `req_error`.
- `req_op_type`  in  `3*N_REQ`  operation type; requester i uses bits `[3i+2:3i]`.
- `req_target`  in  `3*N_REQ`  target chip address, same packing.
- `req_page`  in  `PAGE_W*N_REQ`  page offset, packed in the same way.
- `req_grant`  out  `N_REQ`  one-hot, high from ISSUE through RELEASE.
- `req_done`  out  `N_REQ`  one-cycle pulse when the operation completes.
- `req_error`  out  `N_REQ`  one-cycle pulse when the acknowledge times out.
- `op_en`  out  1  one-cycle operation strobe to the controller.
- `op_type`  out  3  latched operation type.
- `op_target`  out  3  latched target.
- `op_page`  out  `PAGE_W`  latched page offset.
- `controller_rb_l`  in  1  controller ready (1) / busy (0); asynchronous to `clk`.
- `arb_busy`  out  1  high in any state except IDLE.

## Operation
- `controller_rb_l` passes through a two-flop synchronizer, giving `rb_s`. Both flops reset to 1.
- Round-robin pointer `ptr` (`log2(N_REQ)` bits, reset 0). Search starts at index `ptr` and wraps modulo `N_REQ`. The first `req_valid` bit found wins.
- State machine (reset to IDLE):
  - IDLE: if any `req_valid` and `rb_s==1`, latch the winner index and its fields, then go to ISSUE. If `rb_s==0`, stay in IDLE even with requests pending.
  - ISSUE: `op_en=1` for this cycle only. `req_grant` bit is set. Clear the timeout counter and go to WAIT_ACK.
  - WAIT_ACK: if `rb_s==0`, go to WAIT_DONE. Otherwise increment the counter; when the counter reaches `ACK_TIMEOUT-1`, set an error flag and go to RELEASE.
  - WAIT_DONE: if `rb_s==1`, go to RELEASE.
  - RELEASE: pulse `req_done[win]`, or `req_error[win]` if the error flag is set. Clear `req_grant`. Set `ptr = (win+1) mod N_REQ`. Go to IDLE.
- `op_type`, `op_target` and `op_page` hold their latched values from ISSUE until the next ISSUE. They are not cleared in IDLE.
- `req_valid` deasserting while granted is ignored; the operation runs to RELEASE. Fields of non-granted requesters may change freely.
- Timeout counter width is `clog2(ACK_TIMEOUT)+1`. It saturates and never wraps.
- At most one bit of `req_grant`, `req_done` and `req_error` is ever high. `req_done` and `req_error` are never high in the same cycle.

## Timing
- Reset values: `req_grant`, `req_done`, `req_error` all 0; `op_en=0`, `op_type=0`, `op_target=0`, `op_page=0`; `arb_busy=0`; `ptr=0`.
- Reset asserted mid-operation returns every output to its reset value immediately. Resuming any in-flight controller operation is the requester's job.
- `req_valid` sampled high in IDLE at edge T gives `req_grant` and `op_en` high from T+1. `op_en` drops at T+2.
- A `controller_rb_l` edge reaches `rb_s` two cycles later.
- Minimum transaction, from ISSUE to back in IDLE: ISSUE (1) + WAIT_ACK (≥1) + WAIT_DONE (≥1) + RELEASE (1).
- The next grant can be made on the cycle after RELEASE. There is no forced gap beyond that.
- Timeout path: ISSUE, then `ACK_TIMEOUT` cycles in WAIT_ACK, then RELEASE with `req_error`.

## Test plan
- Single request: `req_valid=4'b0100`, op 3/target 5/page 0x1ABC; controller busy for 10 cycles. Expected: `op_en` one cycle with those fields, `req_grant=4'b0100`, `req_done[2]` one pulse, `ptr=3`.
- Fairness: all four requesters hold `req_valid=4'b1111` for 8 transactions. Expected grant order 0,1,2,3,0,1,2,3 with no requester skipped.
- Pointer wrap: from `ptr=3` with `req_valid=4'b0001`, requester 0 is granted; with `4'b1001`, requester 3 is granted first.
- Acknowledge timeout: controller never drops `controller_rb_l`. Expected: `req_error` pulses exactly `ACK_TIMEOUT`+1 cycles after `op_en`, there is no `req_done`, and the next request is still serviced.
- Busy controller in IDLE: `controller_rb_l=0` with requests pending gives no `op_en`. Raising it produces a grant 3 cycles later.
- Reset mid-WAIT_DONE: all outputs return to 0 and `arb_busy=0`. After release, the first grant goes to the lowest-index active request.

Source files
------------

// File: rtl/flash_op_arbiter.sv
// rtl/flash_op_arbiter.sv - round-robin arbiter for the shared flash-controller operation port
module flash_op_arbiter #(
  parameter int N_REQ       = 4,
  parameter int PAGE_W      = 17,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [3*N_REQ-1:0]      req_op_type,
  input  logic [3*N_REQ-1:0]      req_target,
  input  logic [PAGE_W*N_REQ-1:0] req_page,
  output logic [N_REQ-1:0]        req_grant,
  output logic [N_REQ-1:0]        req_done,
  output logic [N_REQ-1:0]        req_error,
  output logic                    op_en,
  output logic [2:0]              op_type,
  output logic [2:0]              op_target,
  output logic [PAGE_W-1:0]       op_page,
  input  logic                    controller_rb_l,
  output logic                    arb_busy
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_WAIT_DONE,
    S_RELEASE
  } state_t;

  state_t           state, state_nxt;
  logic             rb_meta, rb_s;
  logic [PTR_W-1:0] ptr, win, pick;
  logic             found;
  logic [CNT_W-1:0] cnt;
  logic             err;
  logic [N_REQ-1:0] win_oh;

  // Two-flop synchronizer for the controller ready/busy line; idles "ready".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rb_meta <= 1'b1;
      rb_s    <= 1'b1;
    end else begin
      rb_meta <= controller_rb_l;
      rb_s    <= rb_meta;
    end
  end

  // Round-robin search starting at ptr; first valid requester found wins.
  always_comb begin : pick_search
    logic [PTR_W-1:0] sel;
    pick  = '0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sel = PTR_W'((int'(ptr) + k) % N_REQ);
      if (!found && req_valid[sel]) begin
        found = 1'b1;
        pick  = sel;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (found && rb_s) state_nxt = S_ISSUE;
      S_ISSUE:     state_nxt = S_WAIT_ACK;
      S_WAIT_ACK: begin
        if (!rb_s)                 state_nxt = S_WAIT_DONE;
        else if (cnt == CNT_LAST)  state_nxt = S_RELEASE;
      end
      S_WAIT_DONE: if (rb_s) state_nxt = S_RELEASE;
      S_RELEASE:   state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  // Winner/field latch, ack-timeout counter, error flag and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win       <= '0;
      ptr       <= '0;
      cnt       <= '0;
      err       <= 1'b0;
      op_type   <= '0;
      op_target <= '0;
      op_page   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found && rb_s) begin
            win       <= pick;
            op_type   <= req_op_type[3*int'(pick) +: 3];
            op_target <= req_target[3*int'(pick) +: 3];
            op_page   <= req_page[PAGE_W*int'(pick) +: PAGE_W];
          end
        end
        S_ISSUE: begin
          cnt <= '0;
          err <= 1'b0;
        end
        S_WAIT_ACK: begin
          if (rb_s) begin
            if (cnt == CNT_LAST) err <= 1'b1;
            if (cnt != '1)       cnt <= cnt + 1'b1;
          end
        end
        S_RELEASE: begin
          ptr <= (win == PTR_LAST) ? '0 : win + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Per-requester outputs decoded from the registered state and winner.
  always_comb begin
    win_oh    = N_REQ'(1) << win;
    op_en     = (state == S_ISSUE);
    arb_busy  = (state != S_IDLE);
    req_grant = arb_busy ? win_oh : '0;
    req_done  = (state == S_RELEASE && !err) ? win_oh : '0;
    req_error = (state == S_RELEASE &&  err) ? win_oh : '0;
  end

endmodule
